// File: rtl/bram_row_seq_ctrl.sv
// bram_row_seq_ctrl: fills one bram row from a valid/ready stream, then drains it
// through a registered valid/ready output stage, checking the row's done flags.
module bram_row_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_SIZE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err,
    output logic                  bram_rst_n,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_rd_en,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    input  logic                  bram_done,
    input  logic                  bram_read_done
);
    // One extra pointer bit lets rd_ptr reach MEM_SIZE without wrapping.
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] LAST = PW'(MEM_SIZE - 1);
    localparam logic [PW-1:0] FULL = PW'(MEM_SIZE);

    typedef enum logic [2:0] {IDLE, FILL, WAIT_WR, DRAIN, ABORT} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  wait_q, wait_d;
    logic                  chk_q, chk_d;
    logic                  err_q, err_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  done_q, done_d;
    logic                  in_acc, fetch, out_acc, last_acc, timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wait_q      <= 1'b0;
            chk_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wait_q      <= wait_d;
            chk_q       <= chk_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    // abort outranks every other event, so each event is qualified with !abort.
    always_comb begin
        in_acc   = (state_q == FILL) && !abort && in_valid;
        out_acc  = out_valid_q && out_ready;
        fetch    = (state_q == DRAIN) && !abort && (rd_ptr_q < FULL) && (!out_valid_q || out_ready);
        last_acc = (state_q == DRAIN) && !abort && out_acc && out_last_q;
        timeout  = (state_q == WAIT_WR) && !abort && !bram_done && wait_q;
        state_d  = state_q;
        case (state_q)
            IDLE:    state_d = start ? FILL : IDLE;
            FILL:    state_d = abort ? ABORT : (in_acc && wr_ptr_q == LAST) ? WAIT_WR : FILL;
            WAIT_WR: state_d = abort ? ABORT : bram_done ? DRAIN : wait_q ? ABORT : WAIT_WR;
            DRAIN:   state_d = abort ? ABORT : last_acc ? IDLE : DRAIN;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = (state_q == ABORT) ? '0 : in_acc ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d    = (state_q == ABORT || last_acc) ? '0 : fetch ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wait_d      = (state_q == WAIT_WR);
        chk_d       = fetch && (rd_ptr_q == LAST);
        err_d       = (state_q == IDLE && start) ? 1'b0 : (err_q | timeout | (chk_q & !bram_read_done));
        out_valid_d = (state_d != DRAIN) ? 1'b0 : fetch ? 1'b1 : out_acc ? 1'b0 : out_valid_q;
        out_last_d  = (state_d != DRAIN) ? 1'b0 : fetch ? (rd_ptr_q == LAST) : out_acc ? 1'b0 : out_last_q;
        out_data_d  = fetch ? bram_dout : out_data_q;
        done_d      = last_acc;
    end

    always_comb begin
        in_ready     = (state_q == FILL) && !abort;
        bram_we      = in_acc;
        bram_addr    = wr_ptr_q[ADDR_WIDTH-1:0];
        bram_din     = in_data;
        bram_rd_en   = fetch;
        bram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
        bram_rst_n   = !rst && (state_q != ABORT);
        busy         = (state_q != IDLE);
        out_valid    = out_valid_q;
        out_last     = out_last_q;
        out_data     = out_data_q;
        frame_done   = done_q;
        err          = err_q;
    end
endmodule

// File: tb/tb_bram_row_seq_ctrl.sv
// tb_bram_row_seq_ctrl: randomized frames against a queue-based reference model
// with a behavioural row buffer attached to the controller.
module tb_bram_row_seq_ctrl;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int M  = 4;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, fault = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, out_valid, out_last, busy, frame_done, err, bram_rst_n, bram_we, bram_rd_en;
    logic [DW-1:0] out_data, bram_din, bram_dout;
    logic [AW-1:0] bram_addr, bram_rd_addr;
    logic bram_done, bram_read_done;

    always #5 clk = ~clk;

    bram_row_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(M)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .frame_done(frame_done), .err(err), .bram_rst_n(bram_rst_n),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_dout(bram_dout),
        .bram_done(bram_done), .bram_read_done(bram_read_done)
    );

    // Behavioural row: done after the last address is written, read_done after the last address is read.
    logic [DW-1:0] mem [2**AW];
    logic row_done, row_rdone;
    always_ff @(posedge clk) begin
        if (!bram_rst_n) begin
            row_done  <= 1'b0;
            row_rdone <= 1'b0;
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else begin
            if (bram_we) begin
                mem[bram_addr] <= bram_din;
                if (bram_addr == AW'(M - 1)) row_done <= 1'b1;
                else if (bram_addr == '0) row_done <= 1'b0;
            end
            row_rdone <= bram_rd_en && (bram_rd_addr == AW'(M - 1));
        end
    end
    assign bram_dout      = mem[bram_rd_addr];
    assign bram_done      = row_done && !fault;
    assign bram_read_done = row_rdone;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, last_acc_cyc = 0, fd_cyc = 0, first_ov_cyc = -1;
    logic [DW-1:0] m_fill[$], m_out[$];
    logic [DW-1:0] frame [M];
    bit m_filling = 0, exp_fd = 0, prev_stall = 0;
    int m_rd = 0;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_fill = {};
        m_out = {};
        m_filling = 0;
        exp_fd = 0;
        prev_stall = 0;
        m_rd = 0;
        first_ov_cyc = -1;
    endtask

    // Scoreboard: runs at the falling edge, sees what the next rising edge will act on.
    task automatic monitor();
        logic [DW-1:0] e;
        cyc++;
        if (!rst) begin
            if (m_filling || in_ready) chk("in_ready", in_ready, m_filling && !abort);
            if (bram_we || (in_valid && in_ready)) chk("we_on_accept", bram_we, in_valid && in_ready);
            if (in_valid && in_ready) begin
                chk("wr_addr", bram_addr, m_fill.size());
                chk("wr_din", bram_din, in_data);
                m_fill.push_back(in_data);
                if (m_fill.size() == M) begin
                    m_out = m_fill;
                    m_fill = {};
                    m_filling = 0;
                    last_acc_cyc = cyc;
                end
            end
            if (bram_rd_en) begin
                chk("rd_excl_we", bram_we, 0);
                chk("rd_addr", bram_rd_addr, m_rd);
                m_rd++;
            end
            if (out_valid && !out_ready) chk("rd_in_stall", bram_rd_en, 0);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (exp_fd || frame_done) begin
                chk("frame_done", frame_done, exp_fd);
                if (exp_fd) chk("rd_count", m_rd, M);
                fd_cyc = cyc;
                exp_fd = 0;
                m_rd = 0;
            end
            if (out_valid && out_ready) begin
                if (m_out.size() == 0) chk("extra_out", out_valid, 0);
                else begin
                    e = m_out.pop_front();
                    chk("out_data", out_data, e);
                    chk("out_last", out_last, m_out.size() == 0);
                    if (m_out.size() == 0) exp_fd = 1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_filling = 1;
        first_ov_cyc = -1;
    endtask

    // gap: 0 back-to-back, 3 every third cycle, other values random
    task automatic fill(input int gap);
        for (int t = 0; t < 200 && m_filling; t++) begin
            in_valid = (gap == 0) ? 1'b1 : (gap == 3) ? (t % 3 == 0) : 1'($urandom_range(0, 1));
            in_data = frame[m_fill.size()];
            step();
        end
        in_valid = 1'b0;
        if (m_filling) chk("fill_timeout", m_filling, 0);
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0, other values random
    task automatic drain(input int rmode);
        for (int t = 0; t < 200 && (m_out.size() > 0 || exp_fd); t++) begin
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (t % 3 == 0) : 1'($urandom_range(0, 1));
            step();
        end
        out_ready = 1'b0;
        if (m_out.size() > 0 || exp_fd) chk("drain_timeout", m_out.size() + int'(exp_fd), 0);
        chk("frame_err", err, 0);
        chk("frame_idle", busy, 0);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < M; i++) frame[i] = $urandom;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_bram_rst_n", bram_rst_n, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        #1;
        chk("rel_bram_rst_n", bram_rst_n, 1);
        step();

        // basic frame with fixed latency and throughput
        frame = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_start();
        fill(0);
        drain(0);
        chk("first_valid_lat", first_ov_cyc - last_acc_cyc, 3);
        chk("frame_done_lat", fd_cyc - last_acc_cyc, M + 3);

        // backpressure
        frame = '{32'h5a5a0001, 32'h5a5a0002, 32'h5a5a0003, 32'h5a5a0004};
        do_start();
        fill(0);
        drain(1);

        // input gaps
        frame = '{32'hc0, 32'hc1, 32'hc2, 32'hc3};
        do_start();
        fill(3);
        drain(0);
        chk("gap_first_valid_lat", first_ov_cyc - last_acc_cyc, 3);

        // abort ignored in IDLE
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_rst_n", bram_rst_n, 1);

        // abort after two words
        frame = '{32'hdead0000, 32'hdead0001, 32'hdead0002, 32'hdead0003};
        do_start();
        in_valid = 1'b1;
        for (int t = 0; t < 20 && m_fill.size() < 2; t++) begin
            in_data = frame[m_fill.size()];
            step();
        end
        chk("abort_fill_count", m_fill.size(), 2);
        abort = 1'b1;
        in_data = frame[2];
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        model_reset();
        chk("abort_rst_n", bram_rst_n, 0);
        chk("abort_busy", busy, 1);
        step();
        chk("post_abort_busy", busy, 0);
        chk("post_abort_rst_n", bram_rst_n, 1);
        frame = '{32'ha0, 32'ha1, 32'ha2, 32'ha3};
        do_start();
        fill(0);
        drain(0);

        // row never reports done
        fault = 1'b1;
        rand_frame();
        do_start();
        fill(0);
        chk("wait_err0", err, 0);
        chk("wait_busy", busy, 1);
        step();
        chk("wait_err1", err, 0);
        step();
        chk("timeout_err", err, 1);
        chk("timeout_rst_n", bram_rst_n, 0);
        step();
        chk("timeout_idle", busy, 0);
        chk("timeout_err_sticky", err, 1);
        model_reset();
        fault = 1'b0;
        rand_frame();
        do_start();
        chk("start_clears_err", err, 0);
        fill(0);
        drain(0);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            rand_frame();
            do_start();
            fill(int'($urandom_range(0, 3)));
            drain(int'($urandom_range(0, 2)));
        end

        // asynchronous reset mid-drain
        frame = '{32'h51, 32'h52, 32'h53, 32'h54};
        do_start();
        fill(0);
        out_ready = 1'b1;
        for (int t = 0; t < 20 && first_ov_cyc < 0; t++) step();
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rst_n", bram_rst_n, 0);
        chk("arst_rd_en", bram_rd_en, 0);
        model_reset();
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        rand_frame();
        do_start();
        fill(2);
        drain(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
